dbg_slave_cmd_sysclk: RTL and testbench
=======================================

Name: dbg_slave_cmd_sysclk

Overview:
System-clock half of the next-generation CPU debug slave. It receives update events from the JTAG TCK domain as a toggle, plus a stable IR/shift-register snapshot. It queues commands and dispatches each one as a one-cycle take_action/take_no_action strobe on one of NUM_CH channels, with jdo valid alongside. Over the previous fixed 2-bit-IR decoder it adds generic IR/SR widths, a command queue, per-channel back-pressure, overrun and invalid-command reporting.

Parameters:
SR_W, 38, shift-register/jdo width; bit SR_W-1 is the action bit
IR_W, 2, instruction width; channel index = ir
NUM_CH, 4, number of dispatch channels (<= 2**IR_W)
SYNC_STAGES, 2, synchroniser depth for upd_toggle (>= 2)
Q_DEPTH, 4, command queue depth (power of two, >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
upd_toggle  in  1  flips once per TCK-side update-DR; ir/sr stable >= SYNC_STAGES+2 clk after flip
ir  in  IR_W  instruction snapshot
sr  in  SR_W  shift-register snapshot
ch_ready  in  NUM_CH  per-channel consumer ready
overrun_clr  in  1  clears overrun
jdo  out  SR_W  data of last dispatched command, held until next dispatch
take_action  out  NUM_CH  one-hot, one-cycle; action bit = 1
take_no_action  out  NUM_CH  one-hot, one-cycle; action bit = 0
q_level  out  $clog2(Q_DEPTH)+1  queue occupancy
overrun  out  1  sticky: an event was dropped because the queue was full
inv_cnt  out  8  saturating count of commands with ir >= NUM_CH

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0; queue empty; sync chain 0; FSM IDLE; mask counter loaded to SYNC_STAGES+1.
- Sync: upd_toggle passes through SYNC_STAGES flops, then a reference flop. event = stage_last XOR ref. Event is masked while the mask counter is non-zero (counts down once per clk after reset). The ref still tracks during masking, so a toggle already at 1 at reset release produces no false event.
- Enqueue: on event, {ir, sr} is written to the queue tail in the same cycle.
  - Queue full with no pop that cycle: entry dropped, overrun set.
  - Queue full with a simultaneous pop: entry accepted, q_level unchanged.
- overrun clears on overrun_clr. A same-cycle set wins.
- FSM IDLE / ISSUE / GAP:
  - IDLE -> ISSUE when the queue is non-empty.
  - ISSUE, head ir >= NUM_CH: pop, no strobe, inv_cnt+1 (saturates at 255), -> GAP.
  - ISSUE, ch_ready[ir]=1: pop; next cycle jdo = head sr; take_action[ir] = sr[SR_W-1], take_no_action[ir] = ~sr[SR_W-1]; -> GAP.
  - ISSUE, ch_ready[ir]=0: stay in ISSUE, no pop, strobes 0. Head-of-line blocking is intended; order is preserved.
  - GAP -> IDLE after one cycle. This guarantees at least 2 idle cycles between strobes.
- Latency: let clk edge 0 be the first edge sampling the new toggle level, with the queue empty and channel ready. The event is visible after edge SYNC_STAGES. The enqueue is registered at edge SYNC_STAGES+1. The strobe and jdo are valid in the cycle after edge SYNC_STAGES+3 (5 cycles for the defaults).
- Strobes are never asserted on more than one channel, and never for 2 consecutive cycles.
- Reset mid-dispatch: pending strobe suppressed, queue flushed, jdo = 0.

Decomposition:
- dbg_slave_pkg: FSM state enum {IDLE, ISSUE, GAP}; ACT_BIT = SR_W-1 helper function; INV_CNT_W = 8.
- Sub-module dbg_toggle_sync: SYNC_STAGES chain, ref flop, reset mask counter, output event pulse.
- Queue is inline: register array, wrapping head/tail pointers, level counter.

Test Plan:
1. Reset with upd_toggle=1, release, hold 20 cycles -> no strobe, q_level=0, jdo=0.
2. Flip toggle with ir=2, sr=38'h20_0000_00AB, ch_ready=4'hF -> take_action=4'b0100 for exactly 1 cycle, 5 cycles after the first sampling edge; jdo=38'h20_0000_00AB held afterwards.
3. ir=1, sr bit37=0, ch_ready[1]=0 for 10 cycles then 1 -> no strobe while blocked; take_no_action=4'b0010 one cycle after release dispatch.
4. ch_ready=0, 6 toggles spaced 6 cycles -> q_level=4, overrun=1. Set ch_ready=F -> 4 strobes, in order, each >= 3 cycles apart. Then overrun_clr -> overrun=0.
5. NUM_CH=3 build, ir=3 -> no strobe, inv_cnt=1. Repeat 300x -> inv_cnt=255.
6. Assert reset while the queue holds 3 entries mid-ISSUE -> all strobes 0 immediately, q_level=0 after release, no strobe afterwards.

Source files
------------

// File: rtl/dbg_slave_pkg.sv
// Shared types and helpers for the system-clock half of the debug slave.
package dbg_slave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int INV_CNT_W = 8;

  // Position of the action bit inside a shift-register snapshot.
  function automatic int act_bit(input int sr_w);
    return sr_w - 1;
  endfunction

endpackage

// File: rtl/dbg_toggle_sync.sv
// Brings the TCK-side update toggle into clk and emits a one-cycle event per flip,
// ignoring the settling transient right after reset release.
module dbg_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle,
  output logic evt
);

  localparam int MASK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [MASK_W-1:0] MASK_INIT = MASK_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ref_q;
  logic [MASK_W-1:0]      mask_cnt;
  logic                   flip_seen;

  // The reference keeps tracking while masked, so a level already high at release is absorbed.
  assign flip_seen = (sync_q[SYNC_STAGES-1] ^ ref_q) && (mask_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      ref_q    <= 1'b0;
      mask_cnt <= MASK_INIT;
      evt      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle};
      ref_q  <= sync_q[SYNC_STAGES-1];
      evt    <= flip_seen;
      if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/dbg_slave_cmd_sysclk.sv
// Queues synchronised debug update commands and dispatches each as a one-cycle
// take_action / take_no_action strobe on the channel selected by its IR.
module dbg_slave_cmd_sysclk
  import dbg_slave_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int Q_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_toggle,
  input  logic [IR_W-1:0]            ir,
  input  logic [SR_W-1:0]            sr,
  input  logic [NUM_CH-1:0]          ch_ready,
  input  logic                       overrun_clr,
  output logic [SR_W-1:0]            jdo,
  output logic [NUM_CH-1:0]          take_action,
  output logic [NUM_CH-1:0]          take_no_action,
  output logic [$clog2(Q_DEPTH):0]   q_level,
  output logic                       overrun,
  output logic [INV_CNT_W-1:0]       inv_cnt
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = IR_W + SR_W;
  localparam int AB    = act_bit(SR_W);
  localparam logic [IR_W:0]      NUM_CH_L = (IR_W + 1)'(NUM_CH);
  localparam logic [LVL_W-1:0]   Q_FULL   = LVL_W'(Q_DEPTH);

  function automatic logic [INV_CNT_W-1:0] sat_inc(input logic [INV_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [ENT_W-1:0]  q_mem [Q_DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [LVL_W-1:0]  level;
  state_t            state, state_nx;
  logic              evt, full, empty, push, pop, dispatch;
  logic              head_inv, head_rdy;
  logic [IR_W-1:0]   head_ir;
  logic [SR_W-1:0]   head_sr;
  logic [NUM_CH-1:0] head_hot;

  dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .toggle (upd_toggle),
    .evt    (evt)
  );

  // Queue head decode
  assign {head_ir, head_sr} = q_mem[head];
  assign empty    = (level == '0);
  assign full     = (level == Q_FULL);
  assign head_inv = ({1'b0, head_ir} >= NUM_CH_L);

  always_comb begin
    head_hot = '0;
    for (int c = 0; c < NUM_CH; c++) head_hot[c] = (head_ir == IR_W'(c));
  end

  assign head_rdy = |(head_hot & ch_ready);
  assign pop      = (state == ISSUE) && !empty && (head_inv || head_rdy);
  assign dispatch = pop && !head_inv;
  assign push     = evt && (!full || pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!empty) state_nx = ISSUE;
      ISSUE:   if (pop) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Entries are only meaningful between head and tail, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) q_mem[tail] <= {ir, sr};
  end

  // Dispatch register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      level          <= '0;
      overrun        <= 1'b0;
      inv_cnt        <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      jdo            <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (evt && full && !pop) overrun <= 1'b1;
      else if (overrun_clr)    overrun <= 1'b0;
      if (pop && head_inv) inv_cnt <= sat_inc(inv_cnt);
      take_action    <= dispatch ? (head_hot & {NUM_CH{head_sr[AB]}})  : '0;
      take_no_action <= dispatch ? (head_hot & {NUM_CH{~head_sr[AB]}}) : '0;
      if (dispatch) jdo <= head_sr;
    end
  end

  assign q_level = level;

endmodule

// File: tb/tb_dbg_slave_cmd_sysclk.sv
// Scoreboard bench: directed commands push expected strobes; a monitor pops on every strobe.
module tb_dbg_slave_cmd_sysclk;

  typedef struct packed {
    logic [3:0]  ta;
    logic [3:0]  tna;
    logic [37:0] jdo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upd_toggle = 1'b1;
  logic [1:0]  ir = '0;
  logic [37:0] sr = '0;
  logic [3:0]  ch_ready = 4'hF;
  logic        overrun_clr = 1'b0;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  q_level;
  logic        overrun;
  logic [7:0]  inv_cnt;

  logic        tog3 = 1'b1;
  logic [1:0]  ir3 = 2'd3;
  logic [37:0] sr3 = 38'h20_0000_0033;
  logic [2:0]  rdy3 = 3'h7;
  logic        clr3 = 1'b0;
  logic [37:0] jdo3;
  logic [2:0]  ta3, tna3;
  logic [2:0]  lvl3;
  logic        ovr3;
  logic [7:0]  inv3;

  exp_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0, strobe_cnt = 0, last_strobe = -100;

  always #5 clk = ~clk;

  dbg_slave_cmd_sysclk dut (
    .clk(clk), .reset(reset), .upd_toggle(upd_toggle), .ir(ir), .sr(sr),
    .ch_ready(ch_ready), .overrun_clr(overrun_clr), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .q_level(q_level), .overrun(overrun), .inv_cnt(inv_cnt)
  );

  dbg_slave_cmd_sysclk #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .upd_toggle(tog3), .ir(ir3), .sr(sr3),
    .ch_ready(rdy3), .overrun_clr(clr3), .jdo(jdo3),
    .take_action(ta3), .take_no_action(tna3),
    .q_level(lvl3), .overrun(ovr3), .inv_cnt(inv3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic flip(input logic [1:0] i, input logic [37:0] s);
    ir = i;
    sr = s;
    upd_toggle = ~upd_toggle;
  endtask

  task automatic expect_strobe(input logic [3:0] ta, input logic [3:0] tna, input logic [37:0] d);
    exp_t e;
    e.ta = ta;
    e.tna = tna;
    e.jdo = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    bit          hold_chk = 1'b0;
    logic [37:0] hold_val = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          check("jdo_hold", 64'(jdo), 64'(hold_val));
          hold_chk = 1'b0;
        end
        if ((take_action | take_no_action) != 4'h0) begin
          strobe_cnt++;
          check("strobe_onehot", 64'($countones(take_action | take_no_action)), 64'd1);
          check("strobe_gap_ge3", 64'(cyc - last_strobe >= 3), 64'd1);
          last_strobe = cyc;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'({take_action, take_no_action}), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("take_action", 64'(take_action), 64'(e.ta));
            check("take_no_action", 64'(take_no_action), 64'(e.tna));
            check("jdo", 64'(jdo), 64'(e.jdo));
            hold_chk = 1'b1;
            hold_val = e.jdo;
          end
        end
        if ((ta3 | tna3) != 3'h0) check("dut3_strobe", 64'({ta3, tna3}), 64'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sc0, first, width, lat;
    logic [1:0]  t4_ir [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [37:0] t4_sr [6] = '{38'h00_0000_0010, 38'h20_0000_0011, 38'h20_0000_0012,
                               38'h00_0000_0013, 38'h20_0000_0014, 38'h00_0000_0015};
    logic [3:0]  t4_ta [4] = '{4'b0000, 4'b0010, 4'b0100, 4'b0000};
    logic [3:0]  t4_tna[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b1000};

    // 1: reset with toggle high, then idle
    tick(3);
    check("rst_take_action", 64'(take_action), 64'd0);
    check("rst_jdo", 64'(jdo), 64'd0);
    check("rst_q_level", 64'(q_level), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    reset = 1'b0;
    tick(20);
    check("idle_q_level", 64'(q_level), 64'd0);
    check("idle_jdo", 64'(jdo), 64'd0);
    check("idle_strobes", 64'(strobe_cnt), 64'd0);
    check("idle_inv_cnt", 64'(inv_cnt), 64'd0);

    // 2: single action command, exact latency and width
    expect_strobe(4'b0100, 4'b0000, 38'h20_0000_00AB);
    flip(2'd2, 38'h20_0000_00AB);
    first = 0;
    width = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if ((take_action | take_no_action) != 4'h0) begin
        width++;
        if (first == 0) first = i;
      end
    end
    check("t2_latency", 64'(first), 64'd6);
    check("t2_width", 64'(width), 64'd1);
    check("t2_jdo_held", 64'(jdo), 64'h20_0000_00AB);

    // 3: blocked channel, then release
    ch_ready = 4'b1101;
    expect_strobe(4'b0000, 4'b0010, 38'h00_1234_5678);
    sc0 = strobe_cnt;
    flip(2'd1, 38'h00_1234_5678);
    tick(15);
    check("t3_blocked_strobes", 64'(strobe_cnt - sc0), 64'd0);
    check("t3_blocked_level", 64'(q_level), 64'd1);
    ch_ready = 4'hF;
    lat = 0;
    for (int k = 1; k <= 5 && strobe_cnt == sc0; k++) begin
      tick(1);
      lat = k;
    end
    check("t3_release_latency", 64'(lat), 64'd1);
    check("t3_release_strobes", 64'(strobe_cnt - sc0), 64'd1);
    tick(6);

    // 4: fill queue while blocked, overflow, drain in order
    ch_ready = 4'h0;
    sc0 = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) expect_strobe(t4_ta[i], t4_tna[i], t4_sr[i]);
      flip(t4_ir[i], t4_sr[i]);
      tick(6);
    end
    tick(8);
    check("t4_full_level", 64'(q_level), 64'd4);
    check("t4_overrun_set", 64'(overrun), 64'd1);
    check("t4_blocked_strobes", 64'(strobe_cnt - sc0), 64'd0);
    ch_ready = 4'hF;
    tick(25);
    check("t4_drained_strobes", 64'(strobe_cnt - sc0), 64'd4);
    check("t4_drained_level", 64'(q_level), 64'd0);
    check("t4_exp_left", 64'(exp_q.size()), 64'd0);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("t4_overrun_clr", 64'(overrun), 64'd0);

    // 5: invalid IR on the 3-channel build, counter saturation
    tog3 = ~tog3;
    tick(10);
    check("t5_inv_one", 64'(inv3), 64'd1);
    check("t5_level", 64'(lvl3), 64'd0);
    for (int i = 2; i <= 300; i++) begin
      if (i == 255) check("t5_inv_254", 64'(inv3), 64'd254);
      tog3 = ~tog3;
      tick(8);
    end
    tick(10);
    check("t5_inv_sat", 64'(inv3), 64'd255);
    check("t5_overrun", 64'(ovr3), 64'd0);

    // 6: reset while a strobe is live and two entries remain queued
    ch_ready = 4'h0;
    expect_strobe(4'b0001, 4'b0000, 38'h20_0000_0060);
    flip(2'd0, 38'h20_0000_0060);
    tick(6);
    flip(2'd1, 38'h20_0000_0061);
    tick(6);
    flip(2'd2, 38'h20_0000_0062);
    tick(8);
    check("t6_level3", 64'(q_level), 64'd3);
    sc0 = strobe_cnt;
    ch_ready = 4'hF;
    tick(1);
    check("t6_strobe_live", 64'(take_action), 64'b0001);
    reset = 1'b1;
    #1;
    check("t6_rst_take_action", 64'(take_action), 64'd0);
    check("t6_rst_jdo", 64'(jdo), 64'd0);
    check("t6_rst_level", 64'(q_level), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(20);
    check("t6_post_level", 64'(q_level), 64'd0);
    check("t6_post_strobes", 64'(strobe_cnt - sc0), 64'd1);
    check("t6_post_inv3", 64'(inv3), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
